score_tx_ctl: RTL and testbench
===============================

# score_tx_ctl

Transmit-side scheduler for one UART serial link. It snapshots the 6-digit BCD score, packs it into a fixed 5-byte frame and feeds the bytes one at a time to the UART transmitter using a write/busy/done handshake. It replaces the free-running `wr_uart` tie-off and sits between `bin_to_BCD_converter` and a `uart` instance. There is one instance per link.

## Interface
Parameters:
- `REFRESH`, default 750000: cycles between unconditional re-sends of the frame, 10 ms at 75 MHz; minimum value 16.
- `TIMEOUT`, default 16'd60000: maximum cycles to wait for `tx_done_tick` after each write.
- `SYNC`, default 8'hA5: frame start byte.

Ports:
- `pclk` in 1: pixel clock, 75 MHz; the only clock.
- `rst` in 1: asynchronous, active-high reset.
- `points` in 24: BCD score, 6 digits; may change on any cycle.
- `tx_busy` in 1: UART transmitter busy; a write is not issued while it is high.
- `tx_done_tick` in 1: 1-cycle pulse when the UART has finished sending a byte.
- `wr_uart` out 1: 1-cycle write strobe.
- `w_data` out 8: byte to transmit; valid while `wr_uart` is high and held until the next load.
- `frame_active` out 1: high from LOAD until the frame ends.
- `frames_sent` out 8: count of completed frames; wraps from 255 to 0.
- `tx_err` out 1: 1-cycle pulse when a frame is aborted by the timeout.

## Operation
- Frame format, in send order: `SYNC`, `points[23:16]`, `points[15:8]`, `points[7:0]`, then CHK. CHK is the XOR of the first four bytes.
- Registers:
  - `last_sent` (24 bits): score from the most recent LOAD.
  - `frame` (24 bits): snapshot being sent.
  - `idx` (3 bits).
  - `refresh_cnt`: counts every cycle and saturates at `REFRESH-1`.
  - `to_cnt` (16 bits).
- State machine:
  - **IDLE**:
    - Trigger condition: `points != last_sent` OR `refresh_cnt == REFRESH-1`.
    - On trigger: go to LOAD.
  - **LOAD**, one cycle:
    - `frame <= points`, `last_sent <= points`, `idx <= 0`, `refresh_cnt <= 0`, `frame_active <= 1`.
    - Then go to SEND.
  - **SEND**:
    - Wait while `tx_busy` = 1.
    - When `tx_busy` = 0: `w_data <= byte[idx]`, `wr_uart <= 1`, `to_cnt <= 0`, then go to WAIT.
  - **WAIT**:
    - `wr_uart` is cleared after one cycle; `to_cnt` increments each cycle.
    - On `tx_done_tick`:
      - If `idx == 4`: `frames_sent++`, `frame_active <= 0`, go to IDLE.
      - Otherwise: `idx++`, go to SEND.
    - Else if `to_cnt == TIMEOUT-1`: `tx_err <= 1` for one cycle, `frame_active <= 0`, go to IDLE. `last_sent` is kept, so an aborted frame is not retried until the score changes or the refresh expires.
- The score is sampled only in LOAD. A change while a frame is in progress does not alter that frame; IDLE sees the mismatch and starts a new frame.
- `tx_done_tick` is ignored in every state except WAIT.
- If `tx_done_tick` and the timeout occur in the same cycle, `tx_done_tick` wins.

## Timing
- Reset values:
  - State IDLE.
  - `wr_uart`=0, `w_data`=8'h00, `frame_active`=0, `frames_sent`=0, `tx_err`=0.
  - `last_sent`=0, `frame`=0, `idx`=0, `refresh_cnt`=0, `to_cnt`=0.
- All outputs are registered. No combinational path runs from an input to an output.
- Latency when a trigger is seen in IDLE at cycle t:
  - LOAD at t+1, SEND at t+2.
  - `wr_uart`=1 at t+3 if `tx_busy` was 0 at t+2.
  - `w_data` is valid in the same cycle as `wr_uart`.
- Each byte after the first: `wr_uart` follows `tx_done_tick` by 2 cycles, provided `tx_busy` = 0.
- `rst` asserted mid-frame: the current frame is dropped immediately; the UART may still finish its byte. After `rst` is released, the first frame goes out when `points` ≠ 0 or when the refresh expires.
- With `points` constant, frames start every `REFRESH` cycles counted from LOAD, or later if the link is slow.

## Test plan
1. Reset, then set `points`=24'h001234. The UART model raises `tx_done_tick` 20 cycles after each `wr_uart`. Required: `w_data` sequence A5, 00, 12, 34, 83; exactly 5 `wr_uart` pulses, each 1 cycle wide; `frames_sent`=1; `frame_active` high over the whole frame.
2. Use `REFRESH`=200 and hold `points`=24'h000000 after reset. Required: a frame A5, 00, 00, 00, A5 starts 200 cycles after reset, then repeats every 200 cycles.
3. Hold `tx_busy`=1 for 50 cycles before the first byte. Required: no `wr_uart` while `tx_busy` is high; `wr_uart` asserts 1 cycle after `tx_busy` falls.
4. Change `points` from 24'h000100 to 24'h000200 during byte 2. Required: the first frame completes with 00, 01, 00, chk A4; a second frame 00, 02, 00, chk A7 follows immediately; `frames_sent`=2.
5. Use `TIMEOUT`=100 and never send `tx_done_tick`. Required: a `tx_err` pulse 100 cycles after the first `wr_uart`; return to IDLE; `frames_sent` unchanged.
6. Assert `rst` during byte 3. Required: all outputs return to their reset values asynchronously, and the bench sees no further `wr_uart` from the dropped frame.

Source files
------------

// File: rtl/score_tx_ctl_if.sv
// Byte-wide write/busy/done handshake between the frame scheduler and the UART transmitter.
interface score_tx_ctl_if;
    logic       wr_uart;
    logic [7:0] w_data;
    logic       tx_busy;
    logic       tx_done_tick;

    modport master (output wr_uart, output w_data, input tx_busy, input tx_done_tick);
    modport slave  (input wr_uart, input w_data, output tx_busy, output tx_done_tick);
endinterface

// File: rtl/score_tx_ctl.sv
// Snapshots the BCD score and sends it over the UART as SYNC, 3 score bytes, XOR checksum.
//
// state | meaning
// IDLE  | wait for a score change or refresh expiry
// LOAD  | snapshot points, arm the frame
// SEND  | wait for tx_busy low, then issue one byte
// WAIT  | wait for tx_done_tick or timeout
module score_tx_ctl #(
    parameter int          REFRESH = 750000,
    parameter logic [15:0] TIMEOUT = 16'd60000,
    parameter logic [7:0]  SYNC    = 8'hA5
) (
    input  logic           pclk,
    input  logic           rst,
    input  logic [23:0]    points,
    score_tx_ctl_if.master uart,
    output logic           frame_active,
    output logic [7:0]     frames_sent,
    output logic           tx_err
);
    localparam int            RW           = $clog2(REFRESH);
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH - 1);
    localparam logic [15:0]   TO_LAST      = TIMEOUT - 16'd1;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SEND, ST_WAIT} state_t;
    state_t state, state_nxt;

    logic [23:0]   last_sent;
    logic [23:0]   frame;
    logic [2:0]    idx;
    logic [RW-1:0] refresh_cnt;
    logic [15:0]   to_cnt;
    logic          trigger;
    logic          timeout;
    logic [7:0]    chk;
    logic [7:0]    byte_sel;

    assign trigger = (points != last_sent) || (refresh_cnt == REFRESH_LAST);
    assign timeout = (to_cnt == TO_LAST);
    assign chk     = SYNC ^ frame[23:16] ^ frame[15:8] ^ frame[7:0];

    always_comb begin
        case (idx)
            3'd0:    byte_sel = SYNC;
            3'd1:    byte_sel = frame[23:16];
            3'd2:    byte_sel = frame[15:8];
            3'd3:    byte_sel = frame[7:0];
            default: byte_sel = chk;
        endcase
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (trigger) state_nxt = ST_LOAD;
            ST_LOAD: state_nxt = ST_SEND;
            ST_SEND: if (!uart.tx_busy) state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (uart.tx_done_tick) state_nxt = (idx == 3'd4) ? ST_IDLE : ST_SEND;
                else if (timeout)      state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            uart.wr_uart <= 1'b0;
            uart.w_data  <= 8'h00;
            frame_active <= 1'b0;
            frames_sent  <= 8'h00;
            tx_err       <= 1'b0;
            last_sent    <= 24'h0;
            frame        <= 24'h0;
            idx          <= 3'd0;
            refresh_cnt  <= '0;
            to_cnt       <= 16'h0;
        end else begin
            uart.wr_uart <= 1'b0;
            tx_err       <= 1'b0;

            // Cleared on the edge into LOAD so the LOAD-to-LOAD period is exactly REFRESH cycles.
            if (state == ST_IDLE && trigger)    refresh_cnt <= '0;
            else if (refresh_cnt != REFRESH_LAST) refresh_cnt <= refresh_cnt + 1'b1;

            case (state)
                ST_LOAD: begin
                    frame        <= points;
                    last_sent    <= points;
                    idx          <= 3'd0;
                    frame_active <= 1'b1;
                end
                ST_SEND: begin
                    if (!uart.tx_busy) begin
                        uart.w_data  <= byte_sel;
                        uart.wr_uart <= 1'b1;
                        to_cnt       <= 16'h0;
                    end
                end
                ST_WAIT: begin
                    if (uart.tx_done_tick) begin
                        if (idx == 3'd4) begin
                            frames_sent  <= frames_sent + 8'd1;
                            frame_active <= 1'b0;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end else if (timeout) begin
                        // last_sent is kept: an aborted frame waits for a new score or refresh.
                        tx_err       <= 1'b1;
                        frame_active <= 1'b0;
                    end else begin
                        to_cnt <= to_cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_score_tx_ctl.sv
// Directed and randomized checks of score_tx_ctl against a frame-level model and a UART responder.
module tb_score_tx_ctl;
    localparam int          REFRESH = 200;
    localparam logic [15:0] TIMEOUT = 16'd100;
    localparam int          DLY     = 20;

    logic        pclk = 1'b0;
    logic        rst;
    logic [23:0] points;
    logic        frame_active;
    logic [7:0]  frames_sent;
    logic        tx_err;

    score_tx_ctl_if u_if();

    score_tx_ctl #(.REFRESH(REFRESH), .TIMEOUT(TIMEOUT), .SYNC(8'hA5)) dut (
        .pclk(pclk), .rst(rst), .points(points), .uart(u_if.master),
        .frame_active(frame_active), .frames_sent(frames_sent), .tx_err(tx_err)
    );

    always #5 pclk = ~pclk;

    int   n_assert = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    logic busy_seen = 1'b0;
    int   done_dly = DLY;
    bit   done_en  = 1'b1;
    int   done_cnt = 0;
    logic [7:0] wr_q[$];
    int   wr_cyc[$];
    int   err_cyc[$];
    int   wide_cnt = 0, busy_viol = 0, fa_viol = 0, fa_gap = 0;
    logic prev_wr = 1'b0;

    initial forever begin
        @(posedge pclk);
        cyc       = cyc + 1;
        busy_seen = u_if.tx_busy;
    end

    // UART responder and output monitor, all sampled at the falling edge
    initial begin
        u_if.tx_done_tick = 1'b0;
        forever begin
            @(negedge pclk);
            u_if.tx_done_tick = 1'b0;
            if (done_cnt > 0) begin
                done_cnt = done_cnt - 1;
                if (done_cnt == 0) u_if.tx_done_tick = 1'b1;
            end
            if (u_if.wr_uart === 1'b1) begin
                wr_q.push_back(u_if.w_data);
                wr_cyc.push_back(cyc);
                if (prev_wr) wide_cnt++;
                if (busy_seen) busy_viol++;
                if (frame_active !== 1'b1) fa_viol++;
                if (done_en) done_cnt = done_dly;
            end
            if (tx_err === 1'b1) err_cyc.push_back(cyc);
            prev_wr = (u_if.wr_uart === 1'b1);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge pclk);
        #1;
    endtask

    task automatic clear();
        wr_q.delete();
        wr_cyc.delete();
        err_cyc.delete();
    endtask

    function automatic int wr_at(input int i);
        if (i < wr_cyc.size()) return wr_cyc[i];
        return -1;
    endfunction

    function automatic int err_at(input int i);
        if (i < err_cyc.size()) return err_cyc[i];
        return -1;
    endfunction

    function automatic logic [39:0] last5();
        logic [39:0] v;
        int n;
        v = '0;
        n = wr_q.size();
        if (n < 5) return '0;
        for (int i = n - 5; i < n; i++) v = {v[31:0], wr_q[i]};
        return v;
    endfunction

    // Frame model: SYNC, score bytes MSB first, XOR of the four preceding bytes
    function automatic logic [39:0] exp_frame(input logic [23:0] p);
        logic [7:0] b [4];
        logic [7:0] c;
        b[0] = 8'hA5; b[1] = p[23:16]; b[2] = p[15:8]; b[3] = p[7:0];
        c = 8'h00;
        foreach (b[i]) c = c ^ b[i];
        return {b[0], b[1], b[2], b[3], c};
    endfunction

    task automatic wait_frame(input int budget, output bit ok);
        logic [7:0] fs0;
        int n0;
        fs0 = frames_sent;
        n0  = wr_q.size();
        ok  = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (frames_sent !== fs0) begin
                ok = 1'b1;
                break;
            end
            if (wr_q.size() > n0 && frame_active !== 1'b1) fa_gap++;
        end
    endtask

    task automatic wait_wr(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (wr_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    initial begin
        bit ok;
        int c0, c1, r, w, base_fs, hold;
        logic [23:0] p;

        rst = 1'b1; points = 24'h0; u_if.tx_busy = 1'b0;
        repeat (3) step();
        check("rst_wr_uart", u_if.wr_uart, 1'b0);
        check("rst_w_data", u_if.w_data, 8'h00);
        check("rst_frame_active", frame_active, 1'b0);
        check("rst_frames_sent", frames_sent, 8'h00);
        check("rst_tx_err", tx_err, 1'b0);

        // Refresh-only frames with a zero score
        clear(); rst = 1'b0; r = cyc;
        wait_frame(400, ok);
        check("t2_frame1_done", ok, 1'b1);
        check("t2_first_wr_cycle", wr_at(0) - r, 202);
        check("t2_frame1_bytes", last5(), 40'hA5_00_00_00_A5);
        wait_frame(400, ok);
        check("t2_frame2_done", ok, 1'b1);
        check("t2_period", wr_at(5) - wr_at(0), REFRESH);
        check("t2_frame2_bytes", last5(), 40'hA5_00_00_00_A5);
        check("t2_frames_sent", frames_sent, 8'd2);

        // Basic frame
        clear(); points = 24'h001234; c0 = cyc; base_fs = frames_sent;
        wait_frame(400, ok);
        check("t1_done", ok, 1'b1);
        check("t1_latency", wr_at(0) - c0, 3);
        check("t1_bytes", last5(), 40'hA5_00_12_34_83);
        check("t1_wr_count", wr_q.size(), 5);
        check("t1_byte_gap", wr_at(1) - wr_at(0), DLY + 2);
        check("t1_frames_sent", frames_sent, base_fs + 1);

        // Busy before first byte
        clear(); u_if.tx_busy = 1'b1; points = 24'h000777;
        repeat (50) step();
        u_if.tx_busy = 1'b0; c1 = cyc;
        check("t3_no_wr_while_busy", wr_q.size(), 0);
        wait_frame(400, ok);
        check("t3_done", ok, 1'b1);
        check("t3_wr_after_busy", wr_at(0) - c1, 1);
        check("t3_bytes", last5(), exp_frame(24'h000777));

        // Score change mid-frame
        clear(); points = 24'h000100; base_fs = frames_sent;
        wait_wr(2, 200, ok);
        check("t4_reach_byte2", ok, 1'b1);
        points = 24'h000200;
        wait_frame(400, ok);
        check("t4_frame1_done", ok, 1'b1);
        check("t4_frame1_bytes", last5(), 40'hA5_00_01_00_A4);
        wait_frame(400, ok);
        check("t4_frame2_done", ok, 1'b1);
        check("t4_frame2_bytes", last5(), 40'hA5_00_02_00_A7);
        check("t4_back_to_back", wr_at(5) - wr_at(4), DLY + 4);
        check("t4_frames_sent", frames_sent, base_fs + 2);

        // Timeout with no done tick
        clear(); done_en = 1'b0; points = 24'h000500; base_fs = frames_sent;
        wait_wr(1, 50, ok);
        check("t5_first_wr", ok, 1'b1);
        w = wr_at(0);
        repeat (110) step();
        check("t5_err_count", err_cyc.size(), 1);
        check("t5_err_cycle", err_at(0) - w, 100);
        check("t5_wr_count", wr_q.size(), 1);
        check("t5_idle", frame_active, 1'b0);
        check("t5_frames_sent", frames_sent, base_fs);
        done_en = 1'b1;
        wait_frame(400, ok);
        check("t5_retry_done", ok, 1'b1);
        check("t5_retry_delay", wr_at(1) - w, REFRESH);
        check("t5_retry_bytes", last5(), exp_frame(24'h000500));

        // Reset mid-frame
        clear(); points = 24'h654321;
        wait_wr(3, 200, ok);
        check("t6_reach_byte3", ok, 1'b1);
        repeat (5) step();
        #2 rst = 1'b1; points = 24'h0;
        #1;
        check("t6_async_wr_uart", u_if.wr_uart, 1'b0);
        check("t6_async_w_data", u_if.w_data, 8'h00);
        check("t6_async_frame_active", frame_active, 1'b0);
        check("t6_async_frames_sent", frames_sent, 8'h00);
        check("t6_async_tx_err", tx_err, 1'b0);
        clear();
        repeat (30) step();
        check("t6_no_wr_in_reset", wr_q.size(), 0);
        rst = 1'b0; r = cyc;
        repeat (150) step();
        check("t6_no_stale_wr", wr_q.size(), 0);
        wait_frame(300, ok);
        check("t6_refresh_done", ok, 1'b1);
        check("t6_first_wr_cycle", wr_at(0) - r, 202);
        check("t6_bytes", last5(), exp_frame(24'h0));
        check("t6_frames_sent", frames_sent, 8'd1);

        // Randomized scores, done delays and busy holds
        for (int k = 0; k < 12; k++) begin
            p = 24'($urandom());
            if (p == points) p = p ^ 24'h1;
            done_dly = $urandom_range(1, 30);
            hold     = $urandom_range(0, 15);
            clear(); base_fs = frames_sent;
            if (hold > 0) u_if.tx_busy = 1'b1;
            points = p;
            repeat (hold) step();
            u_if.tx_busy = 1'b0;
            wait_frame(400, ok);
            check("rnd_done", ok, 1'b1);
            check("rnd_bytes", last5(), exp_frame(p));
            check("rnd_frames_sent", frames_sent, 8'(base_fs + 1));
        end

        check("wr_pulse_width", wide_cnt, 0);
        check("wr_during_busy", busy_viol, 0);
        check("wr_without_active", fa_viol, 0);
        check("active_gap_in_frame", fa_gap, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
